// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion / multiplexed 7-segment display
// slice: segment code table, blank code, FSM state type and an index-width
// helper.
// -----------------------------------------------------------------------------
package bcd_pkg;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_CODE [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // All segments dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Conversion FSM states.
    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    // Width of a counter/index holding 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
// Combinational BCD digit to active-low 7-segment pattern.
//   digit : 4-bit BCD digit (values above 9 show dark)
//   blank : 1 = force all segments off
//   seg   : {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_encode
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        seg = SEG_OFF;
        if (!blank && (digit < 4'd10)) begin
            seg = SEG_CODE[digit];
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Sequential double-dabble binary-to-BCD converter with a LOAD/BUSY/DONE
// handshake, feeding a prescaled, multiplexed 7-segment display with optional
// leading-zero blanking.
//   CLK        : system clock, rising edge
//   RST_N      : asynchronous active-low reset
//   BIN        : binary value, sampled when LOAD is accepted
//   LOAD       : conversion request, accepted only while idle
//   BLANK_LZ   : 1 = blank leading zero digits (digit 0 is never blanked)
//   BUSY       : conversion in progress
//   DONE       : one-cycle pulse on the edge that updates BCD
//   BCD        : packed result, digit i at [4i+3:4i], digit 0 = units
//   SEG_BIT    : segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   SELECT_BIT : one-hot active-low digit enable, registered
// -----------------------------------------------------------------------------
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH  = 8,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [BIN_WIDTH-1:0]    BIN,
    input  logic                    LOAD,
    input  logic                    BLANK_LZ,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [4*NUM_DIGITS-1:0] BCD,
    output logic [7:0]              SEG_BIT,
    output logic [NUM_DIGITS-1:0]   SELECT_BIT
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = idx_width(BIN_WIDTH);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = idx_width(SCAN_DIV);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (BIN_WIDTH < 1 || BIN_WIDTH > 27) begin : g_bad_bin_width
        $fatal(1, "bcd_scan_display: BIN_WIDTH must be 1..27");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $fatal(1, "bcd_scan_display: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $fatal(1, "bcd_scan_display: SCAN_DIV must be >= 1");
    end
    if ((10 ** NUM_DIGITS) <= ((2 ** BIN_WIDTH) - 1)) begin : g_too_few_digits
        $fatal(1, "bcd_scan_display: NUM_DIGITS too small for BIN_WIDTH");
    end

    // ------------------------------------------------------------------
    // Conversion FSM and datapath
    // ------------------------------------------------------------------
    state_t               state;
    state_t               next_state;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     dabbled;
    logic [BCD_W-1:0]     shifted;
    logic [CNT_W-1:0]     iter_cnt;
    logic [BCD_W-1:0]     bcd_q;
    logic                 done_q;
    logic                 load_accept;
    logic                 last_iter;

    always_comb begin
        next_state  = state;
        load_accept = 1'b0;
        last_iter   = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD) begin
                    load_accept = 1'b1;
                    next_state  = CONV;
                end
            end
            CONV: begin
                if (iter_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One double-dabble step: correct each digit >= 5, then shift the next
    // binary MSB into the units digit.
    always_comb begin
        dabbled = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                dabbled[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {dabbled[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
    end

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            iter_cnt  <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            if (load_accept) begin
                shift_reg <= BIN;
                scratch   <= '0;
                iter_cnt  <= '0;
            end else if (state == CONV) begin
                shift_reg <= shift_reg << 1;
                scratch   <= shifted;
                iter_cnt  <= iter_cnt + CNT_W'(1);
                // Result is published whole on the final step only.
                if (last_iter) begin
                    bcd_q  <= shifted;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign BUSY = (state == CONV);
    assign DONE = done_q;
    assign BCD  = bcd_q;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      scan_idx;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic                  zero_run;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [7:0]            seg_enc;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;

    // upper_zero[i] = digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        sel_onehot           = '0;
        sel_onehot[scan_idx] = 1'b1;
        cur_digit            = bcd_q[4*int'(scan_idx) +: 4];
        cur_blank            = BLANK_LZ && (scan_idx != '0) && upper_zero[scan_idx];
    end

    seg7_encode u_seg7_encode (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_enc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc    <= '0;
            scan_idx <= '0;
            seg_q    <= SEG_OFF;
            sel_q    <= '1;
        end else begin
            if (presc == PRE_W'(SCAN_DIV - 1)) begin
                presc    <= '0;
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                presc <= presc + PRE_W'(1);
            end
            seg_q <= seg_enc;
            sel_q <= ~sel_onehot;
        end
    end

    assign SEG_BIT    = seg_q;
    assign SELECT_BIT = sel_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Directed bench for bcd_scan_display (8-bit/3-digit/SCAN_DIV=4 instance plus
// a 16-bit/5-digit instance).
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bin;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [7:0]  seg_bit;
    logic [2:0]  select_bit;

    logic [15:0] bin16;
    logic        load16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;
    logic [7:0]  seg_bit16;
    logic [4:0]  select_bit16;

    int n_checks;
    int n_fail;

    bcd_scan_display #(
        .BIN_WIDTH  (8),
        .NUM_DIGITS (3),
        .SCAN_DIV   (4)
    ) u_dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .BIN        (bin),
        .LOAD       (load),
        .BLANK_LZ   (blank_lz),
        .BUSY       (busy),
        .DONE       (done),
        .BCD        (bcd),
        .SEG_BIT    (seg_bit),
        .SELECT_BIT (select_bit)
    );

    bcd_scan_display #(
        .BIN_WIDTH  (16),
        .NUM_DIGITS (5),
        .SCAN_DIV   (4)
    ) u_dut16 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .BIN        (bin16),
        .LOAD       (load16),
        .BLANK_LZ   (1'b0),
        .BUSY       (busy16),
        .DONE       (done16),
        .BCD        (bcd16),
        .SEG_BIT    (seg_bit16),
        .SELECT_BIT (select_bit16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  bin;
        logic        blank;
        logic [11:0] bcd;
        logic [23:0] seg;   // {digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one conversion on the 8-bit instance and check handshake timing.
    task automatic convert(input logic [7:0] value, input logic [11:0] exp_bcd, input string tag);
        int busy_cnt;
        int lat;
        bin  = value;
        load = 1'b1;
        tick();
        load = 1'b0;
        bin  = ~value;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (done) lat = c;
            else if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    // Wait for digit i to be selected, then compare its segment pattern.
    task automatic check_digit(input int i, input logic [7:0] exp_seg, input string tag);
        logic [2:0] want;
        logic [2:0] one;
        int n;
        one  = 3'b001;
        want = ~(one << i);
        n    = 0;
        while (select_bit !== want && n < 40) begin
            tick();
            n++;
        end
        if (select_bit === want) check(tag, 32'(seg_bit), 32'(exp_seg));
        else                     check({tag, "_select"}, 32'(select_bit), 32'(want));
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_cnt;
        int lat16;
        logic [2:0] exp_sel;
        logic [2:0] one;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bin      = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        bin16    = '0;
        load16   = 1'b0;

        vecs[0] = '{8'd255, 1'b0, 12'h255, {8'hA4, 8'h92, 8'h92}};
        vecs[1] = '{8'd0,   1'b1, 12'h000, {8'hFF, 8'hFF, 8'hC0}};
        vecs[2] = '{8'd0,   1'b0, 12'h000, {8'hC0, 8'hC0, 8'hC0}};
        vecs[3] = '{8'd105, 1'b1, 12'h105, {8'hF9, 8'hC0, 8'h92}};
        vecs[4] = '{8'd42,  1'b1, 12'h042, {8'hFF, 8'h99, 8'hA4}};
        vecs[5] = '{8'd7,   1'b1, 12'h007, {8'hFF, 8'hFF, 8'hF8}};
        vecs[6] = '{8'd89,  1'b0, 12'h089, {8'hC0, 8'h80, 8'h90}};
        vecs[7] = '{8'd163, 1'b1, 12'h163, {8'hF9, 8'h82, 8'hB0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_seg", 32'(seg_bit), 32'hFF);
        check("rst_select", 32'(select_bit), 32'b111);

        // Scan sequence from reset: each digit held SCAN_DIV=4 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        one   = 3'b001;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_sel = ~(one << (((c - 1) / 4) % 3));
            check($sformatf("scan_c%0d", c), 32'(select_bit), 32'(exp_sel));
        end
        check("scan_seg_zero", 32'(seg_bit), 32'hC0);

        // Table-driven conversions and per-digit display
        for (int v = 0; v < 8; v++) begin
            blank_lz = vecs[v].blank;
            convert(vecs[v].bin, vecs[v].bcd, $sformatf("vec%0d", v));
            for (int d = 0; d < 3; d++) begin
                check_digit(d, vecs[v].seg[8*d +: 8], $sformatf("vec%0d_dig%0d", v, d));
            end
        end

        // LOAD while busy is ignored; LOAD in DONE cycle is accepted.
        bin  = 8'd200;
        load = 1'b1;
        tick();
        load        = 1'b0;
        bin         = 8'd7;
        first_done  = -1;
        second_done = -1;
        done_cnt    = 0;
        for (int c = 1; c <= 30; c++) begin
            load = (c == 3) || (c == 5) || (first_done > 0 && c == first_done + 1);
            tick();
            if (c == 4) check("hold_bcd_mid_conv", 32'(bcd), 32'h163);
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    check("ignored_load_bcd", 32'(bcd), 32'h200);
                end else if (second_done < 0) begin
                    second_done = c;
                    check("b2b_bcd", 32'(bcd), 32'h007);
                end
            end
        end
        load = 1'b0;
        check("ignored_load_first_done", 32'(first_done), 32'd8);
        check("b2b_second_done", 32'(second_done), 32'd17);
        check("b2b_done_count", 32'(done_cnt), 32'd2);

        // Reset mid-conversion
        bin  = 8'd255;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        check("midrst_seg", 32'(seg_bit), 32'hFF);
        check("midrst_select", 32'(select_bit), 32'b111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        convert(8'd42, 12'h042, "post_rst");

        // 16-bit / 5-digit instance
        bin16  = 16'hFFFF;
        load16 = 1'b1;
        tick();
        load16 = 1'b0;
        bin16  = 16'h0000;
        check("w16_busy", 32'(busy16), 32'd1);
        lat16 = 0;
        for (int c = 1; c <= 40 && lat16 == 0; c++) begin
            tick();
            if (done16) lat16 = c;
        end
        check("w16_latency", 32'(lat16), 32'd16);
        check("w16_bcd", 32'(bcd16), 32'h65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
